// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin shared-RAM arbiter.
// Holds the FSM state encoding, default parameters and the index-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_NCORES  = 4;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_RAM_LAT = 1;

    // Never returns less than 1 so that a 1-deep counter still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Core-array and RAM-side bus of the shared-RAM arbiter.
// master = core array / RAM environment, slave = the arbiter itself.
interface mem_arbiter_rr_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [NCORES-1:0]        req_rd;
    logic [NCORES-1:0]        req_wr;
    logic [NCORES-1:0]        lock;
    logic [NCORES*ADDR_W-1:0] addr;
    logic [NCORES*DATA_W-1:0] wdata;
    logic [NCORES-1:0]        ack;
    logic [NCORES*DATA_W-1:0] rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_din;
    logic                     ram_wren;
    logic [DATA_W-1:0]        ram_q;

    modport master (
        output req_rd, req_wr, lock, addr, wdata, ram_q,
        input  ack, rdata, ram_addr, ram_din, ram_wren
    );

    modport slave (
        input  req_rd, req_wr, lock, addr, wdata, ram_q,
        output ack, rdata, ram_addr, ram_din, ram_wren
    );

endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i,
// wrapping from NCORES-1 back to 0.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    localparam int unsigned IDX_W = clog2(NCORES)
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NCORES-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [IDX_W:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NCORES)) begin
                pos = pos - (IDX_W+1)'(NCORES);
            end
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o                = 1'b1;
                idx_o                = pos[IDX_W-1:0];
                gnt_o[pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores.
// Define MEM_ARB_LOCK_EN to let a core hold the RAM across accesses via lock.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int unsigned NCORES  = DEF_NCORES,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RAM_LAT = DEF_RAM_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_rr_if.slave bus
);

    localparam int unsigned IDX_W = clog2(NCORES);
    localparam int unsigned CNT_W = clog2(RAM_LAT);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         gnt_q, gnt_d;
    logic                     wr_q, wr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NCORES-1:0]        ack_q, ack_d;
    logic [NCORES*DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]        ram_din_q, ram_din_d;
    logic                     ram_wren_q, ram_wren_d;
`ifdef MEM_ARB_LOCK_EN
    logic                     own_vld_q, own_vld_d;
    logic [IDX_W-1:0]         own_q, own_d;
`endif

    logic [NCORES-1:0] req_any;
    logic [NCORES-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_vld;
    logic              sel_wr;
    logic              sel_hold;

    assign req_any = bus.req_rd | bus.req_wr;

    rr_arbiter #(.NCORES(NCORES)) u_rr_arbiter (
        .req_i (req_any),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // A requesting lock owner overrides the round-robin choice.
    always_comb begin
        sel_idx  = arb_idx;
        sel_vld  = arb_any;
        sel_wr   = |(arb_gnt & bus.req_wr);
        sel_hold = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        if (own_vld_q && req_any[own_q]) begin
            sel_idx  = own_q;
            sel_vld  = 1'b1;
            sel_wr   = bus.req_wr[own_q];
            sel_hold = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_wren_d = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        own_vld_d  = own_vld_q;
        own_d      = own_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                if (own_vld_q && !req_any[own_q] && !bus.lock[own_q]) begin
                    own_vld_d = 1'b0;
                end
`endif
                if (sel_vld) begin
                    state_d    = ISSUE;
                    gnt_d      = sel_idx;
                    wr_d       = sel_wr;
                    ram_addr_d = bus.addr[sel_idx*ADDR_W +: ADDR_W];
                    ram_din_d  = bus.wdata[sel_idx*DATA_W +: DATA_W];
                    ram_wren_d = sel_wr;
                    if (!sel_hold) begin
                        ptr_d = (sel_idx == IDX_W'(NCORES-1)) ? '0 : sel_idx + IDX_W'(1);
                    end
`ifdef MEM_ARB_LOCK_EN
                    if (!sel_hold && !own_vld_d && bus.lock[sel_idx]) begin
                        own_vld_d = 1'b1;
                        own_d     = sel_idx;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RAM_LAT-1)) begin
                    state_d      = DONE;
                    ack_d[gnt_q] = 1'b1;
                    if (!wr_q) begin
                        rdata_d[gnt_q*DATA_W +: DATA_W] = bus.ram_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
                if (own_vld_q && (own_q == gnt_q) && !bus.lock[gnt_q]) begin
                    own_vld_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wren_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            own_vld_q  <= 1'b0;
            own_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_wren_q <= ram_wren_d;
`ifdef MEM_ARB_LOCK_EN
            own_vld_q  <= own_vld_d;
            own_q      <= own_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rdata    = rdata_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.ram_wren = ram_wren_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr (RAM_LAT=1 and RAM_LAT=3 instances).
module tb_mem_arbiter_rr;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) b1 ();
    mem_arbiter_rr_if #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) b3 ();

    mem_arbiter_rr #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    mem_arbiter_rr #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b1.req_rd = '0; b1.req_wr = '0; b1.lock = '0; b1.addr = '0; b1.wdata = '0; b1.ram_q = '0;
        b3.req_rd = '0; b3.req_wr = '0; b3.lock = '0; b3.addr = '0; b3.wdata = '0; b3.ram_q = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({b1.ack, b1.rdata, b1.ram_addr, b1.ram_din, b1.ram_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_lat1: ack=%b rdata=%h addr=%h din=%h wren=%b, all required 0",
                     b1.ack, b1.rdata, b1.ram_addr, b1.ram_din, b1.ram_wren);
        end
        n_checks++;
        if ({b3.ack, b3.rdata, b3.ram_addr, b3.ram_din, b3.ram_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_lat3: ack=%b rdata=%h addr=%h din=%h wren=%b, all required 0",
                     b3.ack, b3.rdata, b3.ram_addr, b3.ram_din, b3.ram_wren);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        b1.ram_q = 8'h5A;
        b1.addr[2*AW +: AW] = 8'h10;
        b1.req_rd[2] = 1'b1;
        tick();
        n_checks++;
        if (b1.ram_addr !== 8'h10 || b1.ram_wren !== 1'b0 || b1.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_issue: addr=%h wren=%b ack=%b, required 10 0 0000",
                     b1.ram_addr, b1.ram_wren, b1.ack);
        end
        tick();
        n_checks++;
        if (b1.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_wait_ack: ack=%b, required 0000", b1.ack);
        end
        tick();
        n_checks++;
        if (b1.ack !== 4'b0100 || b1.rdata !== 32'h005A_0000) begin
            n_fail++;
            $display("FAIL rd_done: ack=%b rdata=%h, required 0100 005a0000", b1.ack, b1.rdata);
        end
        b1.req_rd = '0;
        tick();
        n_checks++;
        if (b1.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_ack_pulse: ack=%b, required 0000", b1.ack);
        end
    endtask

    task automatic test_write();
        int unsigned wren_cycles = 0;
        b1.addr[1*AW +: AW]  = 8'h22;
        b1.wdata[1*DW +: DW] = 8'hC3;
        b1.req_wr[1] = 1'b1;
        for (int unsigned c = 1; c <= 4; c++) begin
            tick();
            if (b1.ram_wren === 1'b1) wren_cycles++;
            if (c == 1) begin
                n_checks++;
                if (b1.ram_wren !== 1'b1 || b1.ram_din !== 8'hC3 || b1.ram_addr !== 8'h22) begin
                    n_fail++;
                    $display("FAIL wr_issue: wren=%b din=%h addr=%h, required 1 c3 22",
                             b1.ram_wren, b1.ram_din, b1.ram_addr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (b1.ack !== 4'b0010 || b1.rdata !== 32'h005A_0000) begin
                    n_fail++;
                    $display("FAIL wr_done: ack=%b rdata=%h, required 0010 005a0000", b1.ack, b1.rdata);
                end
                b1.req_wr = '0;
            end
        end
        n_checks++;
        if (wren_cycles != 1) begin
            n_fail++;
            $display("FAIL wr_wren_len: wren high %0d cycles, required 1", wren_cycles);
        end
    endtask

    task automatic test_round_robin();
        int unsigned ecore[5] = '{0, 1, 2, 3, 0};
        int unsigned ecyc[5]  = '{3, 7, 11, 15, 19};
        int unsigned cnt[4]   = '{0, 0, 0, 0};
        int unsigned k = 0;
        int unsigned idx;
        rst_n = 1'b0;
        for (int unsigned i = 0; i < NC; i++) b1.addr[i*AW +: AW] = 8'(8'h40 + i);
        b1.req_rd = 4'hF;
        tick();
        rst_n = 1'b1;
        for (int unsigned c = 1; c <= 20; c++) begin
            tick();
            if (b1.ack !== 4'b0000) begin
                idx = 0;
                for (int unsigned i = 0; i < NC; i++) if (b1.ack[i] === 1'b1) idx = i;
                n_checks++;
                if (k >= 5 || $countones(b1.ack) != 1 || idx != ecore[k] || c != ecyc[k]) begin
                    n_fail++;
                    $display("FAIL rr_order: ack=%b at cycle %0d, required core %0d at cycle %0d",
                             b1.ack, c, ecore[k % 5], ecyc[k % 5]);
                end
                if (c <= 16) cnt[idx]++;
                k++;
            end
            if (c == 19) b1.req_rd = '0;
        end
        n_checks++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL rr_count: %0d acks in 20 cycles, required 5", k);
        end
        for (int unsigned i = 0; i < NC; i++) begin
            n_checks++;
            if (cnt[i] != 1) begin
                n_fail++;
                $display("FAIL rr_fair: core %0d got %0d acks in 16 cycles, required 1", i, cnt[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int unsigned spurious = 0;
        logic [NC-1:0] first_ack = '0;
        int unsigned first_cyc = 0;
        b1.addr[0 +: AW] = 8'h33;
        b1.req_rd[0] = 1'b1;
        tick();
        n_checks++;
        if (b1.ram_addr !== 8'h33) begin
            n_fail++;
            $display("FAIL rst_pre_addr: ram_addr=%h, required 33", b1.ram_addr);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b1.ack, b1.rdata, b1.ram_addr, b1.ram_din, b1.ram_wren} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: ack=%b rdata=%h addr=%h din=%h wren=%b, all required 0",
                     b1.ack, b1.rdata, b1.ram_addr, b1.ram_din, b1.ram_wren);
        end
        b1.req_rd = '0;
        for (int unsigned c = 0; c < 5; c++) begin
            tick();
            if (c == 2) rst_n = 1'b1;
            if (b1.ack !== 4'b0000) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rst_no_ack: %0d cycles with ack, required 0", spurious);
        end
        b1.addr[3*AW +: AW]  = 8'h55;
        b1.wdata[3*DW +: DW] = 8'hEE;
        b1.req_wr[3] = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (b1.ram_wren !== 1'b0 || b1.ram_din !== 8'h00 || b1.ram_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_wren_async: wren=%b din=%h addr=%h, required 0 00 00",
                     b1.ram_wren, b1.ram_din, b1.ram_addr);
        end
        b1.req_wr = '0;
        tick();
        rst_n = 1'b1;
        b1.req_rd = 4'b0011;
        for (int unsigned c = 1; c <= 6; c++) begin
            tick();
            if (b1.ack !== 4'b0000 && first_cyc == 0) begin
                first_ack = b1.ack;
                first_cyc = c;
                b1.req_rd = '0;
            end
        end
        b1.req_rd = '0;
        n_checks++;
        if (first_ack !== 4'b0001 || first_cyc != 3) begin
            n_fail++;
            $display("FAIL rst_ptr: first ack=%b at cycle %0d, required 0001 at cycle 3", first_ack, first_cyc);
        end
    endtask

    task automatic test_lat3();
        b3.addr[3*AW +: AW] = 8'h44;
        b3.ram_q = 8'h00;
        b3.req_rd[3] = 1'b1;
        for (int unsigned c = 1; c <= 5; c++) begin
            tick();
            case (c)
                2: b3.ram_q = 8'h11;
                3: b3.ram_q = 8'h22;
                4: b3.ram_q = 8'h77;
                5: b3.ram_q = 8'h99;
                default: ;
            endcase
            if (c == 1) begin
                n_checks++;
                if (b3.ram_addr !== 8'h44) begin
                    n_fail++;
                    $display("FAIL lat3_addr: ram_addr=%h, required 44", b3.ram_addr);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (b3.ack !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL lat3_early_ack: ack=%b in cycle 4, required 0000", b3.ack);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (b3.ack !== 4'b1000 || b3.rdata !== 32'h7700_0000) begin
                    n_fail++;
                    $display("FAIL lat3_done: ack=%b rdata=%h, required 1000 77000000", b3.ack, b3.rdata);
                end
                b3.req_rd = '0;
            end
        end
        tick();
    endtask

    task automatic test_lock();
`ifdef MEM_ARB_LOCK_EN
        int unsigned ecore[4] = '{1, 1, 1, 2};
`else
        int unsigned ecore[4] = '{1, 2, 1, 2};
`endif
        int unsigned ecyc[4] = '{3, 7, 11, 15};
        int unsigned k = 0;
        int unsigned n1 = 0;
        int unsigned idx;
        b1.addr[1*AW +: AW] = 8'h61;
        b1.addr[2*AW +: AW] = 8'h62;
        b1.lock[1]   = 1'b1;
        b1.req_rd[1] = 1'b1;
        b1.req_rd[2] = 1'b1;
        for (int unsigned c = 1; c <= 20; c++) begin
            tick();
            if (b1.ack !== 4'b0000) begin
                idx = 0;
                for (int unsigned i = 0; i < NC; i++) if (b1.ack[i] === 1'b1) idx = i;
                n_checks++;
                if (k >= 4 || $countones(b1.ack) != 1 || idx != ecore[k] || c != ecyc[k]) begin
                    n_fail++;
                    $display("FAIL lock_order: ack=%b at cycle %0d, required core %0d at cycle %0d",
                             b1.ack, c, ecore[k % 4], ecyc[k % 4]);
                end
                if (idx == 1) n1++;
                if (n1 == 3) begin
                    b1.req_rd[1] = 1'b0;
                    b1.lock[1]   = 1'b0;
                end
                k++;
                if (k == 4) begin
                    b1.req_rd = '0;
                    b1.lock   = '0;
                end
            end
        end
        b1.req_rd = '0;
        b1.lock   = '0;
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL lock_count: %0d acks, required 4", k);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_reset_midop();
        test_lat3();
        test_lock();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
